sa_tile_sched: RTL and testbench
================================

// Module: sa_tile_sched
// PURPOSE
//  Tile scheduler in front of sa_matmul: walks an M x N x K grid of array-sized tiles and runs
//  one sa_matmul calculation per (m,n,k) via its start/done handshake. Per tile it supplies base
//  addresses for the weight, input, psum and output buffers, and raises psum-accumulate for k>0.
//  Sits between the host config interface and sa_matmul.
// PARAMETERS
//  ROW     4    array rows (passed through, used for tile depth defaults)
//  COL     4    array columns
//  W_SIZE  256  weight buffer depth (words)
//  I_SIZE  256  input buffer depth (words)
//  O_SIZE  256  output/psum buffer depth (words)
//  W_TILE  ROW  weight words per tile;  I_TILE  16  input words per tile;  O_TILE  16  output words per tile
//  CNT_W   8    width of each tile-count field
// PORTS
//  clk_i          in   1                 clock
//  rstn_i         in   1                 async reset, active low
//  cfg_valid_i    in   1                 host config valid
//  cfg_ready_o    out  1                 scheduler idle, config accepted on valid&ready
//  cfg_m_i        in   CNT_W             M tile count
//  cfg_n_i        in   CNT_W             N tile count
//  cfg_k_i        in   CNT_W             K tile count
//  abort_i        in   1                 abandon the current job
//  mm_start_o     out  1                 start to sa_matmul (level)
//  mm_done_i      in   1                 done from sa_matmul (level)
//  mm_psum_en_o   out  1                 accumulate onto psum (k!=0)
//  wb_base_o      out  $clog2(W_SIZE)    weight tile base = (k*N+n)*W_TILE
//  ib_base_o      out  $clog2(I_SIZE)    input tile base  = (m*K+k)*I_TILE
//  ob_base_o      out  $clog2(O_SIZE)    output tile base = (m*N+n)*O_TILE
//  ps_base_o      out  $clog2(O_SIZE)    psum base = ob_base_o (in-place accumulate)
//  tile_m_o/n_o/k_o out CNT_W            current tile indices
//  busy_o         out  1                 job in progress
//  done_o         out  1                 1-cycle pulse on job completion
//  aborted_o      out  1                 1-cycle pulse on abort
// BEHAVIOUR
//  Reset: state IDLE, cfg_ready_o=1, all other outputs 0, indices 0.
//  FSM: IDLE -> LOAD -> START -> WAIT -> RELEASE -> (START | FINISH) -> IDLE.
//   IDLE:    cfg_ready_o=1. On cfg_valid_i: latch M/N/K, clear indices, go LOAD. Any count 0 -> FINISH.
//   LOAD:    one cycle; bases/psum_en registered from indices (valid before start rises).
//   START:   mm_start_o=1; go WAIT.
//   WAIT:    hold mm_start_o=1 until mm_done_i sampled 1; then mm_start_o=0, go RELEASE.
//   RELEASE: start low; wait for mm_done_i==0 (min 1 cycle). Then advance indices, k innermost,
//            then n, then m; if last tile (m=M-1,n=N-1,k=K-1) go FINISH, else LOAD.
//   FINISH:  done_o=1 one cycle, busy_o drops, go IDLE.
//  busy_o=1 in every state but IDLE. Outputs stable from LOAD until after RELEASE.
//  Tile starts per job = M*N*K exactly; mm_start_o never rises while mm_done_i=1.
//  mm_psum_en_o = (k!=0). Base addresses are computed modulo the buffer depth (truncate to port width).
//  abort_i (any busy state, highest priority): mm_start_o=0 next cycle, aborted_o pulse, no done_o,
//   -> IDLE. Ignored in IDLE. Abort in same cycle as last done: abort wins.
//  cfg_valid_i while busy: ignored (ready=0); host holds valid.
//  Async reset mid-job: all outputs return to reset values immediately; job lost.
// TESTING
//  M=N=K=1, done returned 5 cycles after start -> one start pulse, psum_en=0, bases 0, done_o 1 cycle later.
//  M=1,N=2,K=3, W_TILE=4 -> 6 starts, k sequence 0,1,2,0,1,2; psum_en 0,1,1,0,1,1; wb_base 0,8,16,4,12,20.
//  mm_done_i held high 3 extra cycles after start drops -> next start waits until done low.
//  abort_i asserted in WAIT of tile 2 -> start low next cycle, aborted_o pulse, no done_o, cfg_ready_o=1.
//  cfg_k_i=0 -> zero starts, done_o pulse 2 cycles after accept.
//  rstn_i low during WAIT -> mm_start_o, busy_o, indices 0 asynchronously; fresh config runs cleanly.

Source files
------------

// File: rtl/sa_tile_sched.sv
// Tile scheduler for sa_matmul: walks an M x N x K tile grid (k innermost) and runs one
// start/done handshake per tile, presenting buffer base addresses and psum-accumulate.
module sa_tile_sched #(
  parameter int ROW    = 4,
  parameter int COL    = 4,
  parameter int W_SIZE = 256,
  parameter int I_SIZE = 256,
  parameter int O_SIZE = 256,
  parameter int W_TILE = ROW,
  parameter int I_TILE = 16,
  parameter int O_TILE = 16,
  parameter int CNT_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [CNT_W-1:0]          cfg_m_i,
  input  logic [CNT_W-1:0]          cfg_n_i,
  input  logic [CNT_W-1:0]          cfg_k_i,
  input  logic                      abort_i,
  output logic                      mm_start_o,
  input  logic                      mm_done_i,
  output logic                      mm_psum_en_o,
  output logic [$clog2(W_SIZE)-1:0] wb_base_o,
  output logic [$clog2(I_SIZE)-1:0] ib_base_o,
  output logic [$clog2(O_SIZE)-1:0] ob_base_o,
  output logic [$clog2(O_SIZE)-1:0] ps_base_o,
  output logic [CNT_W-1:0]          tile_m_o,
  output logic [CNT_W-1:0]          tile_n_o,
  output logic [CNT_W-1:0]          tile_k_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      aborted_o
);

  localparam int WA = $clog2(W_SIZE);
  localparam int IA = $clog2(I_SIZE);
  localparam int OA = $clog2(O_SIZE);

  // Base addresses wrap by plain truncation, which is only a modulo for power-of-two depths.
  if (ROW < 1 || COL < 1 || (W_SIZE & (W_SIZE - 1)) != 0 ||
      (I_SIZE & (I_SIZE - 1)) != 0 || (O_SIZE & (O_SIZE - 1)) != 0) begin : g_cfg_check
    $error("sa_tile_sched: array dims must be >0 and buffer depths powers of two");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_RELEASE, S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] m_cnt, n_cnt, k_cnt;
  logic [CNT_W-1:0] m_nxt, n_nxt, k_nxt;
  logic [CNT_W-1:0] n_eff, k_eff;
  logic             idx_ld, last_tile, abort_hit;

  assign abort_hit   = abort_i && (state != S_IDLE);
  assign last_tile   = (tile_m_o == m_cnt - CNT_W'(1)) && (tile_n_o == n_cnt - CNT_W'(1)) &&
                       (tile_k_o == k_cnt - CNT_W'(1));
  // On accept the counts are not latched yet, so the first tile's bases use the live config.
  assign n_eff       = (state == S_IDLE) ? cfg_n_i : n_cnt;
  assign k_eff       = (state == S_IDLE) ? cfg_k_i : k_cnt;

  assign cfg_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign mm_start_o  = (state == S_START) || (state == S_WAIT);
  assign ps_base_o   = ob_base_o;

  always_comb begin
    state_nxt = state;
    idx_ld    = 1'b0;
    m_nxt     = tile_m_o;
    n_nxt     = tile_n_o;
    k_nxt     = tile_k_o;
    unique case (state)
      S_IDLE: begin
        if (cfg_valid_i) begin
          idx_ld    = 1'b1;
          m_nxt     = '0;
          n_nxt     = '0;
          k_nxt     = '0;
          state_nxt = (cfg_m_i == '0 || cfg_n_i == '0 || cfg_k_i == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD:  state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (mm_done_i) state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (!mm_done_i) begin
          if (last_tile) begin
            state_nxt = S_FINISH;
          end else begin
            idx_ld    = 1'b1;
            state_nxt = S_LOAD;
            if (tile_k_o != k_cnt - CNT_W'(1)) begin
              k_nxt = tile_k_o + CNT_W'(1);
            end else begin
              k_nxt = '0;
              if (tile_n_o != n_cnt - CNT_W'(1)) begin
                n_nxt = tile_n_o + CNT_W'(1);
              end else begin
                n_nxt = '0;
                m_nxt = tile_m_o + CNT_W'(1);
              end
            end
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = S_IDLE;
      idx_ld    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= S_IDLE;
      m_cnt        <= '0;
      n_cnt        <= '0;
      k_cnt        <= '0;
      tile_m_o     <= '0;
      tile_n_o     <= '0;
      tile_k_o     <= '0;
      mm_psum_en_o <= 1'b0;
      wb_base_o    <= '0;
      ib_base_o    <= '0;
      ob_base_o    <= '0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_o    <= (state == S_FINISH) && !abort_i;
      aborted_o <= abort_hit;
      if (state == S_IDLE && cfg_valid_i) begin
        m_cnt <= cfg_m_i;
        n_cnt <= cfg_n_i;
        k_cnt <= cfg_k_i;
      end
      // Bases are loaded together with the indices on entry to LOAD, so they lead start.
      if (idx_ld) begin
        tile_m_o     <= m_nxt;
        tile_n_o     <= n_nxt;
        tile_k_o     <= k_nxt;
        mm_psum_en_o <= (k_nxt != '0);
        wb_base_o    <= WA'((WA'(k_nxt) * WA'(n_eff) + WA'(n_nxt)) * WA'(W_TILE));
        ib_base_o    <= IA'((IA'(m_nxt) * IA'(k_eff) + IA'(k_nxt)) * IA'(I_TILE));
        ob_base_o    <= OA'((OA'(m_nxt) * OA'(n_eff) + OA'(n_nxt)) * OA'(O_TILE));
      end
    end
  end

endmodule

// File: tb/tb_sa_tile_sched.sv
// Bench for sa_tile_sched: a job table driven through a responding sa_matmul model, with a
// tile scoreboard checked on every start rise, plus abort, reset and zero-count sequences.
`timescale 1ns/1ps
module tb_sa_tile_sched;

  localparam int W_SIZE = 256;
  localparam int I_SIZE = 256;
  localparam int O_SIZE = 256;
  localparam int W_TILE = 4;
  localparam int I_TILE = 16;
  localparam int O_TILE = 16;

  typedef struct { int m; int n; int k; int dly; int hold; int starts; } job_t;
  typedef struct { int m; int n; int k; int psum; int wb; int ib; int ob; } tile_t;

  logic       clk, rstn, cfg_valid, cfg_ready, abort, mm_start, mm_done, psum_en;
  logic       busy, done, aborted;
  logic [7:0] cfg_m, cfg_n, cfg_k, wb_base, ib_base, ob_base, ps_base, tile_m, tile_n, tile_k;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    start_cnt, done_cnt, abort_cnt;
  int    resp_dly, resp_hold;
  tile_t sb[$];
  int    wb_log[$];
  tile_t mon_e;
  logic  start_q;
  job_t  jobs[8];

  sa_tile_sched #(
    .ROW(4), .COL(4), .W_SIZE(W_SIZE), .I_SIZE(I_SIZE), .O_SIZE(O_SIZE),
    .W_TILE(W_TILE), .I_TILE(I_TILE), .O_TILE(O_TILE), .CNT_W(8)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_m_i(cfg_m), .cfg_n_i(cfg_n), .cfg_k_i(cfg_k), .abort_i(abort),
    .mm_start_o(mm_start), .mm_done_i(mm_done), .mm_psum_en_o(psum_en),
    .wb_base_o(wb_base), .ib_base_o(ib_base), .ob_base_o(ob_base), .ps_base_o(ps_base),
    .tile_m_o(tile_m), .tile_n_o(tile_n), .tile_k_o(tile_k),
    .busy_o(busy), .done_o(done), .aborted_o(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // sa_matmul stand-in: done rises resp_dly cycles after start, held resp_hold extra cycles.
  initial begin
    mm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mm_start && !mm_done) begin
        repeat (resp_dly) @(negedge clk);
        mm_done = 1'b1;
        for (int i = 0; i < 100 && mm_start; i++) @(negedge clk);
        repeat (resp_hold) @(negedge clk);
        mm_done = 1'b0;
      end
    end
  end

  // Scoreboard monitor: each start rise pops one expected tile.
  initial begin
    start_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mm_start && !start_q) begin
        start_cnt++;
        check("start_while_done", int'(mm_done), 0);
        wb_log.push_back(int'(wb_base));
        check("sb_nonempty", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("tile_m", int'(tile_m), mon_e.m);
          check("tile_n", int'(tile_n), mon_e.n);
          check("tile_k", int'(tile_k), mon_e.k);
          check("psum_en", int'(psum_en), mon_e.psum);
          check("wb_base", int'(wb_base), mon_e.wb);
          check("ib_base", int'(ib_base), mon_e.ib);
          check("ob_base", int'(ob_base), mon_e.ob);
          check("ps_base", int'(ps_base), mon_e.ob);
        end
      end
      start_q = mm_start;
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
    end
  end

  task automatic push_expected(input job_t j);
    tile_t t;
    for (int mm = 0; mm < j.m; mm++)
      for (int nn = 0; nn < j.n; nn++)
        for (int kk = 0; kk < j.k; kk++) begin
          t.m    = mm;
          t.n    = nn;
          t.k    = kk;
          t.psum = int'(kk != 0);
          t.wb   = ((kk * j.n + nn) * W_TILE) % W_SIZE;
          t.ib   = ((mm * j.k + kk) * I_TILE) % I_SIZE;
          t.ob   = ((mm * j.n + nn) * O_TILE) % O_SIZE;
          sb.push_back(t);
        end
  endtask

  task automatic issue_cfg(input job_t j);
    resp_dly  = j.dly;
    resp_hold = j.hold;
    start_cnt = 0;
    done_cnt  = 0;
    abort_cnt = 0;
    wb_log.delete();
    push_expected(j);
    @(negedge clk);
    cfg_m     = 8'(j.m);
    cfg_n     = 8'(j.n);
    cfg_k     = 8'(j.k);
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    int guard;
    issue_cfg(j);
    check("busy_on_accept", int'(busy), 1);
    check("ready_on_accept", int'(cfg_ready), 0);
    guard = 0;
    while (done_cnt == 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("job_finished", int'(done_cnt > 0), 1);
    repeat (4) @(negedge clk);
    check("starts", start_cnt, j.starts);
    check("done_pulses", done_cnt, 1);
    check("abort_pulses", abort_cnt, 0);
    check("sb_drained", sb.size(), 0);
    check("ready_after", int'(cfg_ready), 1);
    check("busy_after", int'(busy), 0);
    sb.delete();
  endtask

  task automatic wait_starts(input int n);
    int guard;
    guard = 0;
    while (start_cnt < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("reached_start", int'(start_cnt >= n), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_wb[6];
    jobs[0] = '{1, 1, 1, 5, 0, 1};
    jobs[1] = '{1, 2, 3, 2, 0, 6};
    jobs[2] = '{2, 2, 2, 1, 3, 8};
    jobs[3] = '{3, 1, 2, 3, 1, 6};
    jobs[4] = '{1, 1, 20, 1, 0, 20};
    jobs[5] = '{0, 2, 2, 1, 0, 0};
    jobs[6] = '{2, 3, 1, 2, 2, 6};
    jobs[7] = '{1, 1, 0, 1, 0, 0};
    exp_wb  = '{0, 8, 16, 4, 12, 20};

    rstn = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    cfg_m = '0; cfg_n = '0; cfg_k = '0;
    resp_dly = 1; resp_hold = 0;
    start_cnt = 0; done_cnt = 0; abort_cnt = 0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_start", int'(mm_start), 0);
    check("rst_done", int'(done), 0);
    check("rst_aborted", int'(aborted), 0);
    check("rst_indices", int'({tile_m, tile_n, tile_k}), 0);
    check("rst_bases", int'({wb_base, ib_base, ob_base, psum_en}), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_job(jobs[i]);
      if (jobs[i].m == 1 && jobs[i].n == 2 && jobs[i].k == 3) begin
        check("wb_log_len", wb_log.size(), 6);
        for (int t = 0; t < 6 && t < wb_log.size(); t++) check("wb_seq", wb_log[t], exp_wb[t]);
      end
    end

    // Zero K: no tiles, done exactly two cycles after the accepting edge.
    issue_cfg('{1, 1, 0, 1, 0, 0});
    check("k0_done_early", int'(done), 0);
    check("k0_busy", int'(busy), 1);
    @(posedge clk); #1;
    check("k0_done", int'(done), 1);
    check("k0_ready", int'(cfg_ready), 1);
    @(posedge clk); #1;
    check("k0_done_width", int'(done), 0);
    check("k0_starts", start_cnt, 0);
    sb.delete();

    // Abort while waiting on the second tile.
    issue_cfg('{2, 2, 2, 6, 0, 8});
    wait_starts(2);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_start_low", int'(mm_start), 0);
    check("abort_pulse", int'(aborted), 1);
    check("abort_ready", int'(cfg_ready), 1);
    @(negedge clk);
    abort = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_count", abort_cnt, 1);
    check("abort_starts", start_cnt, 2);
    sb.delete();

    // Asynchronous reset in WAIT of tile (0,0,1).
    issue_cfg('{2, 1, 2, 8, 0, 4});
    wait_starts(2);
    @(negedge clk);
    check("pre_rst_k", int'(tile_k), 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_start", int'(mm_start), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_indices", int'({tile_m, tile_n, tile_k}), 0);
    check("arst_psum", int'(psum_en), 0);
    check("arst_wb", int'(wb_base), 0);
    @(negedge clk);
    rstn = 1'b1;
    sb.delete();
    repeat (20) @(negedge clk);
    check("arst_no_done", done_cnt, 0);
    run_job('{1, 2, 2, 2, 1, 4});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
